// File: rtl/cache_miss_sequencer.sv
// cache_miss_sequencer
//   Miss/refill sequencer for a 4-way, one-word-line, write-back,
//   write-allocate data cache. On a lookup miss it stalls the CPU, writes
//   back a dirty victim, fetches the missing word and installs it in the
//   victim way. The CPU then replays the access and hits.
//
//   Optional feature macro: CACHE_PERF_CNT_EN
//     defined   -> saturating hit/miss lookup counters are built
//     undefined -> no counter flops, o_hit_cnt/o_miss_cnt tie to zero

module cache_miss_sequencer #(
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 22,
    parameter int TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req_valid,
    input  logic               i_req_we,
    input  logic [31:0]        i_req_addr,
    input  logic [31:0]        i_req_wdata,
    input  logic               i_hit,
    input  logic [1:0]         i_victim_way,
    input  logic               i_victim_valid,
    input  logic               i_victim_dirty,
    input  logic [TAG_W-1:0]   i_victim_tag,
    input  logic [31:0]        i_victim_data,
    input  logic               i_mem_ready,
    input  logic [31:0]        i_mem_rdata,
    output logic               o_stall,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [31:0]        o_mem_addr,
    output logic [31:0]        o_mem_wdata,
    output logic               o_line_we,
    output logic [1:0]         o_line_way,
    output logic [INDEX_W-1:0] o_line_index,
    output logic [TAG_W-1:0]   o_line_tag,
    output logic [31:0]        o_line_data,
    output logic               o_line_dirty,
    output logic               o_err,
    output logic [31:0]        o_hit_cnt,
    output logic [31:0]        o_miss_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WB     = 3'd1,
        S_FILL   = 3'd2,
        S_UPDATE = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    // Timer only has to hold TIMEOUT-1 (the last wait cycle before giving up).
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t             r_state;
    state_t             w_next;
    logic [31:2]        r_addr;
    logic               r_we;
    logic [31:0]        r_wdata;
    logic [1:0]         r_vway;
    logic [TAG_W-1:0]   r_vtag;
    logic [31:0]        r_vdata;
    logic [31:0]        r_fill;
    logic [TMR_W-1:0]   r_tmr;
    logic               r_replay;
    logic               w_miss;
    logic               w_tmo;
    logic               w_unused;

    // Byte offset bits are irrelevant for one-word lines.
    assign w_unused = ^i_req_addr[1:0];

    assign w_miss = (r_state == S_IDLE) && i_req_valid && !i_hit;
    // Final allowed wait cycle expired without the memory answering.
    assign w_tmo  = (TIMEOUT != 0) && (r_tmr == TMR_LAST) && !i_mem_ready;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_miss) begin
                    w_next = (i_victim_valid && i_victim_dirty) ? S_WB : S_FILL;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WB: begin
                if (i_mem_ready) begin
                    w_next = S_FILL;
                end else if (w_tmo) begin
                    w_next = S_ERR;
                end else begin
                    w_next = S_WB;
                end
            end
            S_FILL: begin
                if (i_mem_ready) begin
                    w_next = S_UPDATE;
                end else if (w_tmo) begin
                    w_next = S_ERR;
                end else begin
                    w_next = S_FILL;
                end
            end
            S_UPDATE: w_next = S_IDLE;
            S_ERR:    w_next = S_ERR;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode; the miss stall in IDLE is combinational so the CPU freezes at once.
    always_comb begin
        o_stall      = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = 32'd0;
        o_mem_wdata  = 32'd0;
        o_line_we    = 1'b0;
        o_line_way   = 2'd0;
        o_line_index = '0;
        o_line_tag   = '0;
        o_line_data  = 32'd0;
        o_line_dirty = 1'b0;
        o_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_stall = w_miss;
            end
            S_WB: begin
                o_stall     = 1'b1;
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = {r_vtag, r_addr[INDEX_W+1:2], 2'b00};
                o_mem_wdata = r_vdata;
            end
            S_FILL: begin
                o_stall    = 1'b1;
                o_mem_req  = 1'b1;
                o_mem_addr = {r_addr, 2'b00};
            end
            S_UPDATE: begin
                o_stall      = 1'b1;
                o_line_we    = 1'b1;
                o_line_way   = r_vway;
                o_line_index = r_addr[INDEX_W+1:2];
                o_line_tag   = r_addr[31:INDEX_W+2];
                o_line_data  = r_we ? r_wdata : r_fill;
                o_line_dirty = r_we;
            end
            S_ERR: begin
                o_stall = 1'b1;
                o_err   = 1'b1;
            end
            default: begin
                o_stall = 1'b1;
            end
        endcase
    end

    // Capture the missing request and victim so later CPU changes are ignored.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= 32'd0;
            r_vway  <= 2'd0;
            r_vtag  <= '0;
            r_vdata <= 32'd0;
            r_fill  <= 32'd0;
        end else begin
            if (w_miss) begin
                r_addr  <= i_req_addr[31:2];
                r_we    <= i_req_we;
                r_wdata <= i_req_wdata;
                r_vway  <= i_victim_way;
                r_vtag  <= i_victim_tag;
                r_vdata <= i_victim_data;
            end
            if ((r_state == S_FILL) && i_mem_ready) begin
                r_fill <= i_mem_rdata;
            end
        end
    end

    // Memory wait timer: cleared on every state change, counts unanswered wait cycles.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tmr <= '0;
        end else if (w_next != r_state) begin
            r_tmr <= '0;
        end else if (((r_state == S_WB) || (r_state == S_FILL)) && !i_mem_ready) begin
            r_tmr <= r_tmr + TMR_W'(1);
        end else begin
            r_tmr <= r_tmr;
        end
    end

    // Marks the first IDLE cycle after an install, where the CPU replays its access.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_replay <= 1'b0;
        end else begin
            r_replay <= (r_state == S_UPDATE);
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Saturating lookup counters; the post-refill replay hit is not a new lookup.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hit_cnt  <= 32'd0;
            r_miss_cnt <= 32'd0;
        end else if ((r_state == S_IDLE) && i_req_valid) begin
            if (i_hit) begin
                if (!r_replay && (r_hit_cnt != 32'hFFFF_FFFF)) begin
                    r_hit_cnt <= r_hit_cnt + 32'd1;
                end
            end else begin
                if (r_miss_cnt != 32'hFFFF_FFFF) begin
                    r_miss_cnt <= r_miss_cnt + 32'd1;
                end
            end
        end
    end

    assign o_hit_cnt  = r_hit_cnt;
    assign o_miss_cnt = r_miss_cnt;
`else
    assign o_hit_cnt  = 32'd0;
    assign o_miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Self-checking bench for cache_miss_sequencer: directed examples, randomized
// accesses against a transaction-level reference model, reset and timeout.

module tb_cache_miss_sequencer;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, hit;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  victim_way;
    logic        victim_valid, victim_dirty;
    logic [21:0] victim_tag;
    logic [31:0] victim_data;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall, mem_req, mem_we, line_we, line_dirty, err;
    logic [31:0] mem_addr, mem_wdata, line_data, hit_cnt, miss_cnt;
    logic [1:0]  line_way;
    logic [7:0]  line_index;
    logic [21:0] line_tag;

    int n_checks = 0;
    int n_errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        int          dly;
    } txn_t;
    txn_t exp_q[$];

    cache_miss_sequencer #(.INDEX_W(8), .TAG_W(22), .TIMEOUT(TB_TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_we(req_we), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .i_hit(hit), .i_victim_way(victim_way),
        .i_victim_valid(victim_valid), .i_victim_dirty(victim_dirty),
        .i_victim_tag(victim_tag), .i_victim_data(victim_data),
        .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
        .o_stall(stall), .o_mem_req(mem_req), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_line_we(line_we),
        .o_line_way(line_way), .o_line_index(line_index), .o_line_tag(line_tag),
        .o_line_data(line_data), .o_line_dirty(line_dirty), .o_err(err),
        .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_counters();
`ifdef CACHE_PERF_CNT_EN
        check_eq("hit_cnt", 64'(hit_cnt), 64'(exp_hits));
        check_eq("miss_cnt", 64'(miss_cnt), 64'(exp_misses));
`else
        check_eq("hit_cnt_off", 64'(hit_cnt), 64'd0);
        check_eq("miss_cnt_off", 64'(miss_cnt), 64'd0);
`endif
    endtask

    task automatic scramble_cpu();
        req_addr     = $urandom;
        req_we       = 1'($urandom);
        req_wdata    = $urandom;
        victim_way   = 2'($urandom);
        victim_valid = 1'($urandom);
        victim_dirty = 1'($urandom);
        victim_tag   = 22'($urandom);
        victim_data  = $urandom;
    endtask

    // One CPU access. Called just after a posedge; returns just after a posedge.
    task automatic do_access(input bit h, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] vway,
                             input bit vvalid, input bit vdirty, input logic [21:0] vtag,
                             input logic [31:0] vdata, input logic [31:0] rdata,
                             input int dwb, input int dfill);
        int   exp_stall;
        int   n_stall = 0;
        int   n_inst = 0;
        int   waitc = 0;
        bit   done = 0;
        txn_t t;
        req_valid = 1'b1; hit = h; req_we = we; req_addr = addr; req_wdata = wdata;
        victim_way = vway; victim_valid = vvalid; victim_dirty = vdirty;
        victim_tag = vtag; victim_data = vdata;
        if (h) begin
            exp_hits++;
            @(negedge clk);
            check_eq("hit_stall", 64'(stall), 64'd0);
            check_eq("hit_mem_req", 64'(mem_req), 64'd0);
            @(posedge clk); #1;
            req_valid = 1'b0;
            check_counters();
            return;
        end
        exp_misses++;
        exp_q.delete();
        exp_stall = 2;
        if (vvalid && vdirty) begin
            t.we = 1'b1; t.addr = {vtag, addr[9:2], 2'b00}; t.data = vdata; t.dly = dwb;
            exp_q.push_back(t);
            exp_stall += dwb + 1;
        end
        t.we = 1'b0; t.addr = {addr[31:2], 2'b00}; t.data = 32'd0; t.dly = dfill;
        exp_q.push_back(t);
        exp_stall += dfill + 1;
        @(negedge clk);
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (!stall) begin
                done = 1;
                break;
            end
            n_stall++;
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_mem_req", 64'(mem_req), 64'd0);
                end else begin
                    check_eq("mem_we", 64'(mem_we), 64'(exp_q[0].we));
                    check_eq("mem_addr", 64'(mem_addr), 64'(exp_q[0].addr));
                    if (exp_q[0].we) check_eq("mem_wdata", 64'(mem_wdata), 64'(exp_q[0].data));
                    if (waitc == exp_q[0].dly) begin
                        mem_ready = 1'b1;
                        mem_rdata = rdata;
                        void'(exp_q.pop_front());
                        waitc = 0;
                    end else begin
                        waitc++;
                    end
                end
            end
            if (line_we) begin
                n_inst++;
                check_eq("line_way", 64'(line_way), 64'(vway));
                check_eq("line_index", 64'(line_index), 64'(addr[9:2]));
                check_eq("line_tag", 64'(line_tag), 64'(addr[31:10]));
                check_eq("line_data", 64'(line_data), 64'(we ? wdata : rdata));
                check_eq("line_dirty", 64'(line_dirty), 64'(we));
            end
            @(posedge clk); #1;
            mem_ready = 1'b0;
            scramble_cpu();
            req_valid = 1'b1;
            hit = 1'b1;
            @(negedge clk);
        end
        check_eq("miss_done_in_bound", 64'(done), 64'd1);
        check_eq("stall_cycles", 64'(n_stall), 64'(exp_stall));
        check_eq("txns_left", 64'(exp_q.size()), 64'd0);
        check_eq("installs", 64'(n_inst), 64'd1);
        check_eq("replay_mem_req", 64'(mem_req), 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_counters();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req_valid = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        exp_hits = 0; exp_misses = 0;
        @(negedge clk);
        check_eq("rst_stall", 64'(stall), 64'd0);
        check_eq("rst_mem_req", 64'(mem_req), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_line_we", 64'(line_we), 64'd0);
        check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_counters();
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int n_fill;
        bit got_err;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; hit = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; victim_way = 2'd0; victim_valid = 1'b0;
        victim_dirty = 1'b0; victim_tag = 22'd0; victim_data = 32'd0;
        mem_ready = 1'b0; mem_rdata = 32'd0;
        @(posedge clk); #1;
        apply_reset();

        // Directed examples.
        do_access(1, 0, 32'h0000_1234, 32'd0, 2'd1, 0, 0, 22'd0, 32'd0, 32'h0, 0, 0);
        do_access(0, 0, 32'h0000_1234, 32'd0, 2'd2, 1, 0, 22'h5, 32'h0, 32'hDEADBEEF, 0, 1);
        do_access(0, 1, 32'h0000_0404, 32'hCAFE0000, 2'd3, 1, 1, 22'h3, 32'h11111111,
                  32'h55AA55AA, 0, 0);

        // Randomized accesses.
        for (int i = 0; i < 60; i++) begin
            do_access(($urandom_range(0, 2) == 0), 1'($urandom), $urandom, $urandom,
                      2'($urandom), 1'($urandom), 1'($urandom), 22'($urandom), $urandom,
                      $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        // Reset while the write-back is waiting.
        req_valid = 1'b1; hit = 1'b0; req_we = 1'b0; req_addr = 32'h0000_2000;
        victim_valid = 1'b1; victim_dirty = 1'b1; victim_tag = 22'h7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("wb_wait_req", 64'(mem_req), 64'd1);
        check_eq("wb_wait_we", 64'(mem_we), 64'd1);
        @(posedge clk); #1;
        apply_reset();
        do_access(0, 0, 32'h0000_3008, 32'd0, 2'd0, 1, 0, 22'h1, 32'd0, 32'h0BADF00D, 1, 2);

        // Fill never answered: error after TB_TIMEOUT wait cycles.
        req_valid = 1'b1; hit = 1'b0; req_we = 1'b0; req_addr = 32'h0000_4444;
        victim_valid = 1'b0; victim_dirty = 1'b0;
        exp_misses++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_fill = 0;
        got_err = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (err) begin
                got_err = 1;
                break;
            end
            if (mem_req) n_fill++;
            @(posedge clk); #1;
        end
        check_eq("tmo_err_seen", 64'(got_err), 64'd1);
        check_eq("tmo_fill_cycles", 64'(n_fill), 64'(TB_TIMEOUT));
        check_eq("tmo_mem_req", 64'(mem_req), 64'd0);
        check_eq("tmo_stall", 64'(stall), 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("tmo_err_sticky", 64'(err), 64'd1);
        check_eq("tmo_stall_sticky", 64'(stall), 64'd1);
        check_counters();
        @(posedge clk); #1;
        apply_reset();
        do_access(1, 1, 32'h0000_0010, 32'h1, 2'd0, 0, 0, 22'd0, 32'd0, 32'd0, 0, 0);
        do_access(0, 1, 32'h0000_0010, 32'h77, 2'd2, 1, 1, 22'h9, 32'h99, 32'd0, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
